// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter for the register file write port; REGFILE_WB_SCOREBOARD_EN adds busy-bit hazard tracking.
module regfile_wb_arbiter #(
  parameter int RWIDTH = 6,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [RWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [RWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              req1_ready,
  output logic [RWIDTH-1:0] wa,
  output logic [DWIDTH-1:0] wd,
  output logic              we,
  input  logic              rsv_valid,
  input  logic [RWIDTH-1:0] rsv_addr,
  input  logic [RWIDTH-1:0] ra1,
  input  logic [RWIDTH-1:0] ra2,
  output logic              hazard1,
  output logic              hazard2
);
  logic              last;
  logic              xfer;
  logic [RWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_data;
  // last=1 means req1 was granted most recently, so req0 wins the next contention
  assign req0_ready = req0_valid && (!req1_valid || last);
  assign req1_ready = req1_valid && (!req0_valid || !last);
  assign xfer       = req0_ready || req1_ready;
  assign sel_addr   = req1_ready ? req1_addr : req0_addr;
  assign sel_data   = req1_ready ? req1_data : req0_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
      we   <= 1'b0;
      wa   <= '0;
      wd   <= '0;
    end else begin
      we <= xfer && (sel_addr != '0);
      if (xfer) last <= req1_ready;
      if (xfer && (sel_addr != '0)) begin
        wa <= sel_addr;
        wd <= sel_data;
      end
    end
  end
`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [2**RWIDTH-1:0] busy;
  // clear follows the registered write; a same-edge reservation overrides it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (we) busy[wa] <= 1'b0;
      if (rsv_valid && (rsv_addr != '0)) busy[rsv_addr] <= 1'b1;
    end
  end
  assign hazard1 = busy[ra1] && (ra1 != '0);
  assign hazard2 = busy[ra2] && (ra2 != '0);
`else
  logic unused_sb;
  assign unused_sb = ^{rsv_valid, rsv_addr, ra1, ra2};
  assign hazard1   = 1'b0;
  assign hazard2   = 1'b0;
`endif
endmodule
